ihex_loader: RTL and testbench

IHEX_LOADER -- requirements
Module: ihex_loader

---
 rtl/ihex_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_ihex_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ihex_loader.sv
// Intel-HEX record parser: checks each record, writes its data bytes out, answers '.' (ACK) or '!' (NAK).
// One byte per cycle on both rx and write side; i_wr_busy stalls WRITE, i_tx_busy holds RESP.
module ihex_loader #(
  parameter int AW      = 32,
  parameter int MAX_LEN = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_stb,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_stb,
  input  logic          i_tx_busy,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  input  logic          i_wr_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [15:0]   o_rec_cnt
);

  localparam int         IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX8 = 8'(MAX_LEN);

  typedef enum logic [3:0] {
    IDLE, LEN, ADDR, TYPE, DATA, CSUM, CHECK, WRITE, RESP
  } state_t;

  state_t        state;
  logic [7:0]    mem [0:MAX_LEN-1];
  logic [7:0]    sum, len, rtype, idx;
  logic [15:0]   addr, ext;
  logic [3:0]    hi;
  logic          half, bsel, ack;
  logic [AW-1:0] base;

  logic          hex_ok, is_colon, in_field, byte_done;
  logic [3:0]    nib;
  logic [7:0]    byte_val, idx_nxt;

  always_comb begin
    hex_ok = 1'b1;
    nib    = 4'h0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39)
      nib = i_rx_data[3:0];
    else if ((i_rx_data >= 8'h61 && i_rx_data <= 8'h66) ||
             (i_rx_data >= 8'h41 && i_rx_data <= 8'h46))
      nib = i_rx_data[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  assign is_colon  = (i_rx_data == 8'h3A);
  assign in_field  = (state == LEN) || (state == ADDR) || (state == TYPE) ||
                     (state == DATA) || (state == CSUM);
  assign byte_val  = {hi, nib};
  assign byte_done = i_rx_stb && in_field && !is_colon && hex_ok && half;
  assign idx_nxt   = idx + 8'd1;

  // Buffer is deliberately not reset; contents only matter once a record is complete.
  always_ff @(posedge i_clk) begin
    if (byte_done && state == DATA)
      mem[idx[IW-1:0]] <= byte_val;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      sum       <= 8'h00;
      len       <= 8'h00;
      rtype     <= 8'h00;
      idx       <= 8'h00;
      addr      <= 16'h0000;
      ext       <= 16'h0000;
      hi        <= 4'h0;
      half      <= 1'b0;
      bsel      <= 1'b0;
      ack       <= 1'b0;
      base      <= '0;
      o_tx_data <= 8'h00;
      o_tx_stb  <= 1'b0;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= 8'h00;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rec_cnt <= 16'h0000;
    end else begin
      o_tx_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_stb && is_colon) begin
            sum   <= 8'h00;
            half  <= 1'b0;
            state <= LEN;
          end
        end

        LEN, ADDR, TYPE, DATA, CSUM: begin
          if (i_rx_stb) begin
            if (is_colon) begin
              sum   <= 8'h00;
              half  <= 1'b0;
              state <= LEN;
            end else if (!hex_ok) begin
              ack   <= 1'b0;
              state <= RESP;
            end else if (!half) begin
              hi   <= nib;
              half <= 1'b1;
            end else begin
              half <= 1'b0;
              sum  <= sum + byte_val;
              case (state)
                LEN: begin
                  len  <= byte_val;
                  bsel <= 1'b0;
                  if (byte_val > MAX8) begin
                    ack   <= 1'b0;
                    state <= RESP;
                  end else begin
                    state <= ADDR;
                  end
                end
                ADDR: begin
                  bsel <= 1'b1;
                  if (!bsel) begin
                    addr[15:8] <= byte_val;
                  end else begin
                    addr[7:0] <= byte_val;
                    state     <= TYPE;
                  end
                end
                TYPE: begin
                  rtype <= byte_val;
                  idx   <= 8'h00;
                  state <= (len == 8'h00) ? CSUM : DATA;
                end
                DATA: begin
                  // ext keeps the last two data bytes for extended-address records
                  ext <= {ext[7:0], byte_val};
                  idx <= idx_nxt;
                  if (idx == len - 8'd1)
                    state <= CSUM;
                end
                default: state <= CHECK;
              endcase
            end
          end
        end

        CHECK: begin
          state <= RESP;
          ack   <= 1'b0;
          if (sum == 8'h00) begin
            case (rtype)
              8'h00: begin
                ack <= 1'b1;
                if (len != 8'h00) begin
                  ack       <= 1'b0;
                  idx       <= 8'h00;
                  o_wr_stb  <= 1'b1;
                  o_wr_addr <= base + AW'(addr);
                  o_wr_data <= mem[0];
                  state     <= WRITE;
                end
              end
              8'h01: begin
                ack    <= 1'b1;
                o_done <= 1'b1;
              end
              8'h02: begin
                if (len == 8'd2) begin
                  base <= AW'({ext, 4'h0});
                  ack  <= 1'b1;
                end
              end
              8'h04: begin
                if (len == 8'd2) begin
                  base <= AW'({ext, 16'h0000});
                  ack  <= 1'b1;
                end
              end
              default: ack <= 1'b0;
            endcase
          end
        end

        WRITE: begin
          if (!i_wr_busy) begin
            if (idx == len - 8'd1) begin
              o_wr_stb <= 1'b0;
              ack      <= 1'b1;
              state    <= RESP;
            end else begin
              idx       <= idx_nxt;
              o_wr_addr <= o_wr_addr + AW'(1);
              o_wr_data <= mem[idx_nxt[IW-1:0]];
            end
          end
        end

        RESP: begin
          if (!i_tx_busy) begin
            o_tx_stb  <= 1'b1;
            o_tx_data <= ack ? 8'h2E : 8'h21;
            if (ack)
              o_rec_cnt <= o_rec_cnt + 16'd1;
            else
              o_err <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ihex_loader.sv
// Directed bench for ihex_loader: a record table plus hand sequences for tx stall and mid-write reset.
module tb_ihex_loader;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_stb;
  logic [7:0]  o_tx_data;
  logic        o_tx_stb;
  logic        i_tx_busy;
  logic        o_wr_stb;
  logic [31:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        i_wr_busy;
  logic        o_done;
  logic        o_err;
  logic [15:0] o_rec_cnt;

  ihex_loader #(.AW(32), .MAX_LEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_stb(i_rx_stb),
    .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb), .i_tx_busy(i_tx_busy),
    .o_wr_stb(o_wr_stb), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_busy(i_wr_busy),
    .o_done(o_done), .o_err(o_err), .o_rec_cnt(o_rec_cnt)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          wr_tog = 1'b0;
  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];
  logic [7:0]  tx_q[$];

  // Transfers happen on the next rising edge exactly when stb && !busy here.
  always @(negedge i_clk) begin
    cyc++;
    if (o_wr_stb && !i_wr_busy) begin
      wa_q.push_back(o_wr_addr);
      wd_q.push_back(o_wr_data);
      wc_q.push_back(cyc);
    end
    if (o_tx_stb)
      tx_q.push_back(o_tx_data);
  end

  initial begin
    i_wr_busy = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_wr_busy = wr_tog ? ~i_wr_busy : 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] c);
    i_rx_data = c;
    i_rx_stb  = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_stb  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  task automatic wait_resp(input string name);
    int k;
    k = 0;
    while (tx_q.size() < 1 && k < 300) begin
      @(posedge i_clk);
      k++;
    end
    if (tx_q.size() < 1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no response expected one within 300 cycles", name);
    end
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] packed_data();
    logic [31:0] d;
    d = 32'h0;
    foreach (wd_q[i]) d = {d[23:0], wd_q[i]};
    return d;
  endfunction

  typedef struct {
    string       rec;
    bit          tog;
    logic [7:0]  resp;
    int          nwr;
    logic [31:0] addr;
    logic [31:0] dat;
    int          cnt;
    bit          err;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{":0300300002337A1E",  1'b0, 8'h2E, 3, 32'h00000030, 32'h0002337A, 1, 1'b0};
    vt[1]  = '{":0300300002337A1F",  1'b0, 8'h21, 0, 32'h0,        32'h0,        1, 1'b1};
    vt[2]  = '{":020000040001F9",    1'b0, 8'h2E, 0, 32'h0,        32'h0,        2, 1'b1};
    vt[3]  = '{":0100000055AA",      1'b0, 8'h2E, 1, 32'h00010000, 32'h00000055, 3, 1'b1};
    vt[4]  = '{":03003000G",         1'b0, 8'h21, 0, 32'h0,        32'h0,        3, 1'b1};
    vt[5]  = '{":0300:0100000055AA", 1'b0, 8'h2E, 1, 32'h00010000, 32'h00000055, 4, 1'b1};
    vt[6]  = '{":0300300002337A1E",  1'b1, 8'h2E, 3, 32'h00010030, 32'h0002337A, 5, 1'b1};
    vt[7]  = '{":020000022000DC",    1'b0, 8'h2E, 0, 32'h0,        32'h0,        6, 1'b1};
    vt[8]  = '{":01002000ab34",      1'b0, 8'h2E, 1, 32'h00020020, 32'h000000AB, 7, 1'b1};
    vt[9]  = '{":020000040000FA",    1'b0, 8'h2E, 0, 32'h0,        32'h0,        8, 1'b1};
    vt[10] = '{"xyz:0100100011DE",   1'b0, 8'h2E, 1, 32'h00000010, 32'h00000011, 9, 1'b1};
    vt[11] = '{":21",                1'b0, 8'h21, 0, 32'h0,        32'h0,        9, 1'b1};
    vt[12] = '{":00000003FD",        1'b0, 8'h21, 0, 32'h0,        32'h0,        9, 1'b1};
    vt[13] = '{":0100000400FB",      1'b0, 8'h21, 0, 32'h0,        32'h0,        9, 1'b1};

    i_reset   = 1'b1;
    i_rx_data = 8'h00;
    i_rx_stb  = 1'b0;
    i_tx_busy = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_strobes", {30'h0, o_tx_stb, o_wr_stb}, 32'h0);
    check("rst_flags",   {30'h0, o_done, o_err}, 32'h0);
    check("rst_cnt",     {16'h0, o_rec_cnt}, 32'h0);
    check("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
    check("rst_wr_addr", o_wr_addr, 32'h0);
    check("rst_wr_data", {24'h0, o_wr_data}, 32'h0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    for (int v = 0; v < 14; v++) begin
      clear_q();
      wr_tog = vt[v].tog;
      send_str(vt[v].rec);
      wait_resp($sformatf("v%0d", v));
      wr_tog = 1'b0;
      check($sformatf("v%0d_nresp", v), tx_q.size(), 1);
      if (tx_q.size() > 0)
        check($sformatf("v%0d_resp", v), {24'h0, tx_q[0]}, {24'h0, vt[v].resp});
      check($sformatf("v%0d_nwr", v), wa_q.size(), vt[v].nwr);
      if (wa_q.size() > 0 && vt[v].nwr > 0) begin
        check($sformatf("v%0d_addr0", v), wa_q[0], vt[v].addr);
        check($sformatf("v%0d_addr_last", v), wa_q[wa_q.size()-1], vt[v].addr + vt[v].nwr - 1);
        check($sformatf("v%0d_data", v), packed_data(), vt[v].dat);
        if (!vt[v].tog)
          check($sformatf("v%0d_back2back", v), wc_q[wc_q.size()-1] - wc_q[0], vt[v].nwr - 1);
      end
      check($sformatf("v%0d_cnt", v), {16'h0, o_rec_cnt}, vt[v].cnt);
      check($sformatf("v%0d_err", v), {31'h0, o_err}, {31'h0, vt[v].err});
      check($sformatf("v%0d_done", v), {31'h0, o_done}, 32'h0);
    end

    // EOF record while the transmitter stays busy for 10 cycles
    clear_q();
    i_tx_busy = 1'b1;
    send_str(":00000001FF");
    repeat (10) @(posedge i_clk);
    #1;
    check("eof_held_nresp", tx_q.size(), 0);
    check("eof_done_early", {31'h0, o_done}, 32'h1);
    i_tx_busy = 1'b0;
    wait_resp("eof");
    check("eof_nresp", tx_q.size(), 1);
    if (tx_q.size() > 0)
      check("eof_resp", {24'h0, tx_q[0]}, 32'h2E);
    check("eof_cnt", {16'h0, o_rec_cnt}, 32'd10);

    // Records keep being processed after EOF
    clear_q();
    send_str(":010040007748");
    wait_resp("post_eof");
    check("post_eof_nwr", wa_q.size(), 1);
    if (wa_q.size() > 0)
      check("post_eof_addr", wa_q[0], 32'h40);
    check("post_eof_data", packed_data(), 32'h77);
    check("post_eof_cnt", {16'h0, o_rec_cnt}, 32'd11);
    check("post_eof_done", {31'h0, o_done}, 32'h1);

    // Asynchronous reset in the middle of a stalled write burst
    clear_q();
    wr_tog = 1'b1;
    send_str(":0300300002337A1E");
    begin
      int k;
      k = 0;
      while (!o_wr_stb && k < 50) begin
        @(negedge i_clk);
        k++;
      end
      check("rst_wr_reached", {31'h0, o_wr_stb}, 32'h1);
    end
    #2;
    i_reset = 1'b1;
    #1;
    check("rst_mid_wr_stb", {31'h0, o_wr_stb}, 32'h0);
    check("rst_mid_flags",  {30'h0, o_done, o_err}, 32'h0);
    check("rst_mid_cnt",    {16'h0, o_rec_cnt}, 32'h0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    wr_tog  = 1'b0;
    @(posedge i_clk);
    #1;
    clear_q();
    send_str(":0100000055AA");
    wait_resp("after_rst");
    if (tx_q.size() > 0)
      check("after_rst_resp", {24'h0, tx_q[0]}, 32'h2E);
    check("after_rst_nwr", wa_q.size(), 1);
    if (wa_q.size() > 0)
      check("after_rst_addr", wa_q[0], 32'h0);
    check("after_rst_data", packed_data(), 32'h55);
    check("after_rst_cnt", {16'h0, o_rec_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
